// File: rtl/alu_operand_dispatch.sv
// Per-stage action engine front/back end: decodes each lane's VLIW action into ALU
// operands, issues every lane in one cycle and rebuilds the PHV from lane results.
module alu_operand_dispatch #(
    parameter int STAGE_ID   = 0,
    parameter int NUM_LANES  = 8,
    parameter int DATA_WIDTH = 48,
    parameter int ACTION_LEN = 64,
    parameter int TIMEOUT    = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_LANES*DATA_WIDTH-1:0]  phv_in,
    input  logic [NUM_LANES*ACTION_LEN-1:0]  action_vec_in,
    input  logic                             phv_in_valid,
    output logic                             phv_in_ready,
    output logic [NUM_LANES*ACTION_LEN-1:0]  alu_action,
    output logic [NUM_LANES-1:0]             alu_action_valid,
    output logic [NUM_LANES*DATA_WIDTH-1:0]  alu_operand_1,
    output logic [NUM_LANES*DATA_WIDTH-1:0]  alu_operand_2,
    input  logic [NUM_LANES*DATA_WIDTH-1:0]  alu_container,
    input  logic [NUM_LANES-1:0]             alu_container_valid,
    output logic [NUM_LANES*DATA_WIDTH-1:0]  phv_out,
    output logic                             phv_out_valid,
    input  logic                             phv_out_ready,
    output logic                             err_timeout,
    output logic                             err_stray
);
    localparam int PHV_W = NUM_LANES * DATA_WIDTH;
    localparam int ACT_W = NUM_LANES * ACTION_LEN;
    localparam int IDX_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_OUTPUT} state_t;

    state_t                 state_reg, state_next;
    logic                   ready_reg;
    logic [ACT_W-1:0]       action_reg;
    logic [PHV_W-1:0]       op1_reg, op2_reg, op1_next, op2_next;
    logic [PHV_W-1:0]       result_reg, result_next;
    logic [NUM_LANES-1:0]   done_reg, done_next;
    logic [TMR_W-1:0]       timer_reg, timer_next;
    logic                   err_timeout_reg, err_stray_reg;
    logic                   accept, timeout_hit, stray_hit;
    logic [DATA_WIDTH-1:0]  phv_in_arr [NUM_LANES];

    // STAGE_ID is informational only.
    logic unused_stage;
    assign unused_stage = ^32'(STAGE_ID);

    generate
        for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_decode
            logic [7:0]            opc;
            logic [IDX_W-1:0]      idx1, idx2;
            logic [DATA_WIDTH-1:0] imm, op1, op2;

            assign phv_in_arr[gi] = phv_in[gi*DATA_WIDTH +: DATA_WIDTH];
            assign opc  = action_vec_in[gi*ACTION_LEN + 56 +: 8];
            // Mask keeps the select in range for any power-of-two lane count.
            assign idx1 = action_vec_in[gi*ACTION_LEN + 48 +: IDX_W] & IDX_W'(NUM_LANES - 1);
            assign idx2 = action_vec_in[gi*ACTION_LEN + 40 +: IDX_W] & IDX_W'(NUM_LANES - 1);
            assign imm  = DATA_WIDTH'(action_vec_in[gi*ACTION_LEN +: 48]);

            always_comb begin
                op1 = phv_in_arr[gi];
                op2 = '0;
                case (opc)
                    8'h01, 8'h02: begin
                        op1 = phv_in_arr[idx1];
                        op2 = phv_in_arr[idx2];
                    end
                    8'h09, 8'h0A: begin
                        op1 = phv_in_arr[idx1];
                        op2 = imm;
                    end
                    8'h0E: op2 = imm;
                    default: ;
                endcase
            end

            assign op1_next[gi*DATA_WIDTH +: DATA_WIDTH] = op1;
            assign op2_next[gi*DATA_WIDTH +: DATA_WIDTH] = op2;
        end
    endgenerate

    always_comb begin
        state_next  = state_reg;
        result_next = result_reg;
        done_next   = done_reg;
        timer_next  = timer_reg;
        accept      = 1'b0;
        timeout_hit = 1'b0;
        stray_hit   = 1'b0;
        case (state_reg)
            S_IDLE: begin
                stray_hit = |alu_container_valid;
                if (ready_reg && phv_in_valid) begin
                    accept      = 1'b1;
                    result_next = phv_in;
                    state_next  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                stray_hit  = |alu_container_valid;
                done_next  = '0;
                timer_next = '0;
                state_next = S_WAIT;
            end
            S_WAIT: begin
                for (int i = 0; i < NUM_LANES; i++) begin
                    if (alu_container_valid[i]) begin
                        result_next[i*DATA_WIDTH +: DATA_WIDTH] = alu_container[i*DATA_WIDTH +: DATA_WIDTH];
                        done_next[i] = 1'b1;
                    end
                end
                // Completion wins over timeout when the last valid lands on the final cycle.
                if (&done_next) begin
                    state_next = S_OUTPUT;
                end else if (timer_reg == TMR_W'(TIMEOUT - 1)) begin
                    state_next  = S_OUTPUT;
                    timeout_hit = 1'b1;
                end else begin
                    timer_next = timer_reg + 1'b1;
                end
            end
            S_OUTPUT: begin
                stray_hit = |alu_container_valid;
                if (phv_out_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= S_IDLE;
            ready_reg       <= 1'b0;
            action_reg      <= '0;
            op1_reg         <= '0;
            op2_reg         <= '0;
            result_reg      <= '0;
            done_reg        <= '0;
            timer_reg       <= '0;
            err_timeout_reg <= 1'b0;
            err_stray_reg   <= 1'b0;
        end else begin
            state_reg       <= state_next;
            ready_reg       <= (state_next == S_IDLE);
            result_reg      <= result_next;
            done_reg        <= done_next;
            timer_reg       <= timer_next;
            err_timeout_reg <= timeout_hit;
            err_stray_reg   <= stray_hit;
            if (accept) begin
                action_reg <= action_vec_in;
                op1_reg    <= op1_next;
                op2_reg    <= op2_next;
            end
        end
    end

    assign phv_in_ready     = ready_reg;
    assign alu_action       = action_reg;
    assign alu_action_valid = {NUM_LANES{state_reg == S_ISSUE}};
    assign alu_operand_1    = op1_reg;
    assign alu_operand_2    = op2_reg;
    assign phv_out          = result_reg;
    assign phv_out_valid    = (state_reg == S_OUTPUT);
    assign err_timeout      = err_timeout_reg;
    assign err_stray        = err_stray_reg;

endmodule

// File: tb/tb_alu_operand_dispatch.sv
// Scoreboard bench for alu_operand_dispatch: a stub ALU answers each lane with a
// programmable latency, and a reference model predicts the rebuilt PHV.
`timescale 1ns/1ps
module tb_alu_operand_dispatch;
    localparam int N   = 8;
    localparam int DW  = 48;
    localparam int AL  = 64;
    localparam int TMO = 16;
    localparam int PW  = N * DW;
    localparam int AW  = N * AL;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [PW-1:0] phv_in = '0;
    logic [AW-1:0] action_vec_in = '0;
    logic          phv_in_valid = 1'b0;
    logic          phv_in_ready;
    logic [AW-1:0] alu_action;
    logic [N-1:0]  alu_action_valid;
    logic [PW-1:0] alu_operand_1, alu_operand_2;
    logic [PW-1:0] alu_container = '0;
    logic [N-1:0]  alu_container_valid = '0;
    logic [PW-1:0] phv_out;
    logic          phv_out_valid;
    logic          phv_out_ready = 1'b1;
    logic          err_timeout, err_stray;

    alu_operand_dispatch #(
        .STAGE_ID(0), .NUM_LANES(N), .DATA_WIDTH(DW), .ACTION_LEN(AL), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .phv_in(phv_in), .action_vec_in(action_vec_in),
        .phv_in_valid(phv_in_valid), .phv_in_ready(phv_in_ready),
        .alu_action(alu_action), .alu_action_valid(alu_action_valid),
        .alu_operand_1(alu_operand_1), .alu_operand_2(alu_operand_2),
        .alu_container(alu_container), .alu_container_valid(alu_container_valid),
        .phv_out(phv_out), .phv_out_valid(phv_out_valid), .phv_out_ready(phv_out_ready),
        .err_timeout(err_timeout), .err_stray(err_stray)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        logic [PW-1:0] phv;
        bit            tmo;
        int            lat;
        int            acc;
    } exp_t;

    exp_t         sb_q[$];
    int           n_checks = 0;
    int           n_pass = 0;
    int           cyc = 0;
    int           stray_seen = 0;
    int           n_txn = 0;
    int           rdy_mode = 0;
    int           stray_req_cnt = 0;
    int           lat_cfg [N];
    logic [N-1:0] drop_cfg = '0;
    bit           prev_v = 1'b0;

    task automatic chk(input string name, input logic [AW-1:0] got, input logic [AW-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s: got no event expected event at %0t", name, $time);
    endtask

    // Reference: each lane's result from the opcode rules applied to the input PHV.
    function automatic logic [PW-1:0] model(input logic [PW-1:0] p, input logic [AW-1:0] a,
                                            input logic [N-1:0] drop);
        logic [DW-1:0] c [N];
        logic [AL-1:0] w;
        logic [DW-1:0] r, imm;
        logic [PW-1:0] o;
        int            i1, i2;
        for (int i = 0; i < N; i++) c[i] = p[i*DW +: DW];
        o = '0;
        for (int i = 0; i < N; i++) begin
            w   = a[i*AL +: AL];
            i1  = int'(w[50:48]) % N;
            i2  = int'(w[42:40]) % N;
            imm = w[47:0];
            case (w[63:56])
                8'h01:   r = c[i1] + c[i2];
                8'h02:   r = c[i1] - c[i2];
                8'h09:   r = c[i1] + imm;
                8'h0A:   r = c[i1] - imm;
                8'h0E:   r = imm;
                default: r = c[i];
            endcase
            if (drop[i]) r = c[i];
            o[i*DW +: DW] = r;
        end
        return o;
    endfunction

    function automatic logic [DW-1:0] alu_fn(input logic [7:0] opc, input logic [DW-1:0] x,
                                             input logic [DW-1:0] y);
        case (opc)
            8'h01, 8'h09: return x + y;
            8'h02, 8'h0A: return x - y;
            8'h0E:        return y;
            default:      return x;
        endcase
    endfunction

    function automatic logic [AL-1:0] mk_act(input logic [7:0] opc, input logic [2:0] idx1,
                                             input logic [47:0] low);
        return {opc, 5'b0, idx1, low};
    endfunction

    function automatic logic [7:0] rand_opc();
        case ($urandom_range(0, 6))
            0: return 8'h00;
            1: return 8'h01;
            2: return 8'h02;
            3: return 8'h09;
            4: return 8'h0A;
            5: return 8'h0E;
            default: return 8'($urandom());
        endcase
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Stub ALU: lane i answers lat_cfg[i] cycles after issue unless dropped.
    initial begin
        int            cnt [N];
        logic [DW-1:0] res [N];
        logic [N-1:0]  v;
        int            stray_done;
        stray_done = 0;
        for (int i = 0; i < N; i++) begin
            cnt[i] = 0;
            res[i] = '0;
        end
        forever begin
            @(negedge clk);
            #1;
            v = '0;
            for (int i = 0; i < N; i++) begin
                if (cnt[i] > 0) begin
                    cnt[i]--;
                    if (cnt[i] == 0) begin
                        v[i] = 1'b1;
                        alu_container[i*DW +: DW] = res[i];
                    end
                end
            end
            if (stray_req_cnt != stray_done) begin
                v[0] = 1'b1;
                stray_done++;
            end
            for (int i = 0; i < N; i++) begin
                if (alu_action_valid[i] && !drop_cfg[i]) begin
                    cnt[i] = lat_cfg[i];
                    res[i] = alu_fn(alu_action[i*AL+56 +: 8], alu_operand_1[i*DW +: DW],
                                    alu_operand_2[i*DW +: DW]);
                end
            end
            alu_container_valid = v;
        end
    end

    initial forever begin
        @(negedge clk);
        #1;
        case (rdy_mode)
            0:       phv_out_ready = 1'b1;
            1:       phv_out_ready = 1'($urandom_range(0, 1));
            default: phv_out_ready = 1'b0;
        endcase
    end

    // Monitor: samples after all drivers have settled for the coming edge.
    initial forever begin
        exp_t e;
        @(negedge clk);
        #2;
        if (!rst_n) begin
            prev_v = 1'b0;
            sb_q.delete();
            continue;
        end
        if (err_stray) stray_seen++;
        if (phv_out_valid) begin
            chk("in_ready_while_busy", phv_in_ready, 0);
            if (sb_q.size() == 0) begin
                fail_now("unexpected_output");
            end else begin
                e = sb_q[0];
                if (!prev_v) begin
                    chk("err_timeout", err_timeout, e.tmo);
                    chk("latency", cyc - e.acc, e.lat);
                end else begin
                    chk("err_timeout_hold", err_timeout, 0);
                end
                chk("phv_out", phv_out, e.phv);
                if (phv_out_ready) begin
                    void'(sb_q.pop_front());
                    n_txn++;
                    $display("txn %0d accepted@%0d out@%0d phv_out=%h", n_txn, e.acc, cyc + 1, phv_out);
                end
            end
        end else begin
            chk("err_timeout_idle", err_timeout, 0);
        end
        prev_v = phv_out_valid && !phv_out_ready;
    end

    task automatic send(input logic [PW-1:0] p, input logic [AW-1:0] a, output int acc);
        exp_t e;
        int   lmax;
        bit   ok;
        phv_in = p;
        action_vec_in = a;
        phv_in_valid = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (phv_in_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        acc = cyc + 1;
        if (!ok) begin
            fail_now("accept_timeout");
            phv_in_valid = 1'b0;
            return;
        end
        chk("accept_after_handshake", sb_q.size(), 0);
        lmax = 0;
        for (int i = 0; i < N; i++) if (!drop_cfg[i] && lat_cfg[i] > lmax) lmax = lat_cfg[i];
        e.phv = model(p, a, drop_cfg);
        e.tmo = |drop_cfg;
        e.lat = e.tmo ? 1 + TMO : 1 + lmax;
        e.acc = acc;
        sb_q.push_back(e);
        @(negedge clk);
        phv_in_valid = 1'b0;
        #2;
    endtask

    task automatic set_lat(input int l);
        for (int i = 0; i < N; i++) lat_cfg[i] = l;
        drop_cfg = '0;
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (sb_q.size() == 0 && !phv_out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now("drain_timeout");
        repeat (2) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, phv_in_ready, 0);
        chk({tag, "_out_valid"}, phv_out_valid, 0);
        chk({tag, "_phv_out"}, phv_out, 0);
        chk({tag, "_action"}, alu_action, 0);
        chk({tag, "_action_valid"}, alu_action_valid, 0);
        chk({tag, "_operands"}, alu_operand_1 | alu_operand_2, 0);
        chk({tag, "_errs"}, {err_timeout, err_stray}, 0);
    endtask

    task automatic rand_txn(output logic [PW-1:0] p, output logic [AW-1:0] a);
        logic [AL-1:0] w;
        for (int i = 0; i < N; i++) begin
            p[i*DW +: DW] = DW'({$urandom(), $urandom()});
            w = {$urandom(), $urandom()};
            w[63:56] = rand_opc();
            a[i*AL +: AL] = w;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [PW-1:0] p;
        logic [AW-1:0] a;
        int            acc0, acc1;
        bit            seen;

        set_lat(2);
        #1;
        check_reset_outputs("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("ready_after_reset", phv_in_ready, 1);

        // Add: container0 = 10 + 3 with a 2-cycle ALU.
        p = '0;
        p[0*DW +: DW] = 48'd10;
        p[1*DW +: DW] = 48'd3;
        for (int i = 2; i < N; i++) p[i*DW +: DW] = DW'(i * 100);
        a = '0;
        a[0*AL +: AL] = mk_act(8'h01, 3'd0, {5'b0, 3'd1, 40'b0});
        send(p, a, acc0);
        drain();

        // Immediate subtract with wrap and immediate set.
        set_lat(1);
        a = '0;
        a[1*AL +: AL] = mk_act(8'h0A, 3'd1, 48'd5);
        a[2*AL +: AL] = mk_act(8'h0E, 3'd5, 48'hABCD);
        send(p, a, acc0);
        drain();

        // Backpressure: output held, a second PHV waits for the handshake.
        rdy_mode = 2;
        rand_txn(p, a);
        send(p, a, acc0);
        rand_txn(p, a);
        fork
            send(p, a, acc1);
            begin
                seen = 1'b0;
                for (int k = 0; k < 50; k++) begin
                    @(negedge clk);
                    if (phv_out_valid) begin
                        seen = 1'b1;
                        break;
                    end
                end
                if (!seen) fail_now("stall_output_timeout");
                repeat (5) begin
                    @(negedge clk);
                    chk("stall_in_ready", phv_in_ready, 0);
                    chk("stall_out_valid", phv_out_valid, 1);
                end
                rdy_mode = 0;
            end
        join
        drain();

        // Lane 3 late by two cycles, then lane 3 never returns.
        rand_txn(p, a);
        a[3*AL +: AL] = mk_act(8'h0E, 3'd0, 48'h123456);
        set_lat(1);
        lat_cfg[3] = 3;
        send(p, a, acc0);
        drain();
        set_lat(1);
        drop_cfg[3] = 1'b1;
        send(p, a, acc0);
        drain();
        set_lat(1);

        // Stray valid in IDLE.
        @(negedge clk);
        stray_req_cnt++;
        @(negedge clk);
        chk("err_stray_pulse", err_stray, 1);
        chk("stray_no_output", phv_out_valid, 0);
        @(negedge clk);
        chk("err_stray_clear", err_stray, 0);

        // Back-to-back with a 1-cycle ALU.
        rand_txn(p, a);
        send(p, a, acc0);
        rand_txn(p, a);
        send(p, a, acc1);
        chk("initiation_interval", acc1 - acc0, 4);
        drain();

        // Reset in WAIT; the late ALU answers land in IDLE as a stray.
        set_lat(6);
        rand_txn(p, a);
        send(p, a, acc0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("ready_after_mid_reset", phv_in_ready, 1);
        repeat (8) @(negedge clk);
        set_lat(2);
        rand_txn(p, a);
        send(p, a, acc0);
        drain();

        // Randomized traffic with random backpressure and occasional lost lanes.
        rdy_mode = 1;
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < N; i++) lat_cfg[i] = $urandom_range(1, 4);
            drop_cfg = ($urandom_range(0, 7) == 0) ? (N'(1) << $urandom_range(0, N - 1)) : '0;
            rand_txn(p, a);
            send(p, a, acc0);
        end
        rdy_mode = 0;
        drain();

        chk("stray_pulses", stray_seen, 2);
        chk("scoreboard_empty", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
